// File: rtl/video_pkg.sv
// Shared types for the video mode sequencer: FSM states, the mixer
// configuration bundle and the major/minor classification helper.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        APPLY,
        SETTLE
    } state_t;

    typedef struct packed {
        logic [1:0] scanlines;
        logic       sd_disable;
        logic       hq2x;
        logic       ypbpr;
        logic       ypbpr_full;
    } vid_cfg_t;

    // Fields that alter sync timing or the doubler path; these need blanking.
    function automatic logic major_diff(vid_cfg_t a, vid_cfg_t b);
        return (a.sd_disable != b.sd_disable) ||
               (a.hq2x       != b.hq2x)       ||
               (a.ypbpr      != b.ypbpr);
    endfunction

endpackage

// File: rtl/video_mode_sequencer_vsync_edge_watchdog.sv
// Frame-edge detector on the VSync falling edge; with VIDEO_MODE_SEQ_WATCHDOG_EN
// defined, also emits a synthetic edge after VS_TIMEOUT cycles without one.
module vsync_edge_watchdog #(
    parameter logic [23:0] VS_TIMEOUT = 24'd2_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic VSync,
    output logic fe
);

    logic old_vs;
    logic vs_fall;

    always_ff @(posedge clk_sys) begin
        if (reset)
            old_vs <= 1'b0;
        else
            old_vs <= VSync;
    end

    assign vs_fall = old_vs & ~VSync;

`ifdef VIDEO_MODE_SEQ_WATCHDOG_EN
    logic [23:0] wd_cnt;
    logic        timeout;

    assign timeout = (wd_cnt == VS_TIMEOUT - 24'd1);
    assign fe      = vs_fall | timeout;

    always_ff @(posedge clk_sys) begin
        if (reset || fe)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 24'd1;
    end
`else
    assign fe = vs_fall;
`endif

endmodule

// File: rtl/video_mode_sequencer.sv
// Applies OSD-requested mixer settings on VSync boundaries, wrapping sync-affecting
// changes in a blank/apply/settle sequence. Optional: VIDEO_MODE_SEQ_WATCHDOG_EN.
import video_pkg::*;

module video_mode_sequencer #(
    parameter int unsigned BLANK_FRAMES  = 2,
    parameter int unsigned SETTLE_FRAMES = 3,
    parameter logic [23:0] VS_TIMEOUT    = 24'd2_000_000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       VSync,
    input  logic [1:0] req_scanlines,
    input  logic       req_sd_disable,
    input  logic       req_hq2x,
    input  logic       req_ypbpr,
    input  logic       req_ypbpr_full,
    output logic [1:0] scanlines,
    output logic       scandoubler_disable,
    output logic       hq2x,
    output logic       ypbpr,
    output logic       ypbpr_full,
    output logic       blank,
    output logic       busy
);

    localparam logic [3:0] BLANK_CNT  = 4'(BLANK_FRAMES);
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_FRAMES);

    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15 || SETTLE_FRAMES < 1 ||
        SETTLE_FRAMES > 15 || VS_TIMEOUT == 24'd0) begin : g_bad_param
        $error("video_mode_sequencer: frame counts must be 1..15, VS_TIMEOUT nonzero");
    end

    state_t     state, state_nxt;
    logic [3:0] frame_cnt, cnt_nxt;
    vid_cfg_t   cfg, cfg_nxt, req;
    logic       fe;

    assign req = {req_scanlines, req_sd_disable, req_hq2x, req_ypbpr, req_ypbpr_full};

    vsync_edge_watchdog #(
        .VS_TIMEOUT(VS_TIMEOUT)
    ) u_edge (
        .clk_sys(clk_sys),
        .reset  (reset),
        .VSync  (VSync),
        .fe     (fe)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= SETTLE;
            frame_cnt <= SETTLE_CNT;
            cfg       <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= cnt_nxt;
            cfg       <= cfg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = frame_cnt;
        cfg_nxt   = cfg;
        case (state)
            IDLE: begin
                if (fe) begin
                    if (major_diff(req, cfg)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = BLANK_CNT;
                    end else begin
                        cfg_nxt.scanlines  = req.scanlines;
                        cfg_nxt.ypbpr_full = req.ypbpr_full;
                    end
                end
            end
            BLANK: begin
                if (fe) begin
                    if (frame_cnt == 4'd1)
                        state_nxt = APPLY;
                    else
                        cnt_nxt = frame_cnt - 4'd1;
                end
            end
            APPLY: begin
                cfg_nxt   = req;
                state_nxt = SETTLE;
                cnt_nxt   = SETTLE_CNT;
            end
            SETTLE: begin
                if (fe) begin
                    // A major request that moved during settle is re-applied without re-blanking.
                    if (frame_cnt == 4'd1)
                        state_nxt = major_diff(req, cfg) ? APPLY : IDLE;
                    else
                        cnt_nxt = frame_cnt - 4'd1;
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    assign scanlines           = cfg.scanlines;
    assign scandoubler_disable = cfg.sd_disable;
    assign hq2x                = cfg.hq2x;
    assign ypbpr               = cfg.ypbpr;
    assign ypbpr_full          = cfg.ypbpr_full;
    assign blank               = (state != IDLE);
    assign busy                = (state != IDLE);

endmodule
